// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
//
// Shared definitions for the XNOR-feedback LFSR pattern generator and the
// prbs_checker that receives its stream. Keeping the next-bit function here
// means the transmit and receive sides compute the feedback the same way.
//
// Contents:
//   prbs_state_t     checker state encoding (FILL, SEARCH, LOCKED)
//   PRBS_MAX_WIDTH   widest LFSR the helper function accepts
//   PRBS_TAP_HI_OFS  tap offset below the register length (tap = width-1)
//   PRBS_TAP_LO_OFS  tap offset below the register length (tap = width-2)
//   prbs_next()      next generated bit for a register of a given length
// ---------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    localparam int PRBS_MAX_WIDTH  = 64;
    localparam int PRBS_TAP_HI_OFS = 1;
    localparam int PRBS_TAP_LO_OFS = 2;

    // The register is passed zero-extended to PRBS_MAX_WIDTH so one function
    // serves every LFSR length. The XNOR of the two top taps is the bit that
    // the generator shifts in next, and therefore also the bit it transmits.
    function automatic logic prbs_next(input logic [PRBS_MAX_WIDTH-1:0] lfsr,
                                       input int width);
        logic [5:0] tap_hi;
        logic [5:0] tap_lo;
        tap_hi = 6'(width - PRBS_TAP_HI_OFS);
        tap_lo = 6'(width - PRBS_TAP_LO_OFS);
        return ~(lfsr[tap_hi] ^ lfsr[tap_lo]);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//
// Receive-side checker for the XNOR-feedback LFSR pattern generator. It fills
// a local LFSR copy straight from the incoming bits, confirms that copy by
// requiring LOCK_COUNT consecutive correct predictions, and then free-runs the
// copy so every received bit that disagrees is counted as a bit error. After
// LOSS_COUNT consecutive disagreements it drops lock and resynchronises.
//
// Parameters:
//   WIDTH       LFSR length (>= 3), taps at WIDTH-1 and WIDTH-2, XNOR feedback
//   LOCK_COUNT  consecutive correct predictions needed to lock (>= 1)
//   LOSS_COUNT  consecutive mispredictions while locked that force resync
//   ERR_CNT_W   width of the saturating error counter
//
// Ports:
//   clk_i      in   sole clock, rising edge
//   rst_i      in   synchronous active-high reset
//   d_i        in   received serial bit
//   d_valid_i  in   qualifies d_i; beats with this low change nothing
//   clr_i      in   synchronous clear of err_cnt_o (wins over an increment)
//   locked_o   out  high while in LOCKED
//   err_o      out  one-cycle pulse per mispredicted bit while LOCKED
//   err_cnt_o  out  saturating count of mispredicted bits while LOCKED
// ---------------------------------------------------------------------------
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 d_i,
    input  logic                 d_valid_i,
    input  logic                 clr_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [FILL_W-1:0]    FILL_LAST  = FILL_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]    MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    prbs_state_t          state_q;
    prbs_state_t          state_d;
    logic [WIDTH-1:0]     lfsr_q;
    logic [WIDTH-1:0]     lfsr_d;
    logic [FILL_W-1:0]    fill_cnt_q;
    logic [FILL_W-1:0]    fill_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q;
    logic [MATCH_W-1:0]   match_cnt_d;
    logic [MISS_W-1:0]    miss_cnt_q;
    logic [MISS_W-1:0]    miss_cnt_d;

    logic                 locked_q;
    logic                 locked_d;
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic                 pred;
    logic                 lfsr_stuck;

    // The predicted bit is what the generator would transmit next if its
    // register equalled our local copy. The all-ones register is the XNOR
    // lock-up state: it predicts 1 forever, so it must never earn a match,
    // otherwise a stuck-high line would look like a healthy stream.
    assign pred       = prbs_next(PRBS_MAX_WIDTH'(lfsr_q), WIDTH);
    assign lfsr_stuck = &lfsr_q;

    // State register: FSM state, local LFSR copy and the three small
    // counters. Reset is synchronous, so the bit presented during a reset
    // cycle never reaches the LFSR.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            lfsr_q      <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Next-state logic. Nothing moves unless d_valid_i is high, which lets
    // the link insert idle beats anywhere without disturbing sync.
    //   FILL:   shift raw bits in until the copy holds WIDTH real bits.
    //   SEARCH: keep shifting raw bits, but count how many in a row agree
    //           with the prediction; enough agreements prove the copy.
    //   LOCKED: shift the prediction instead of the received bit, so a bad
    //           bit is counted once and does not corrupt later predictions.
    //           A run of LOSS_COUNT misses means we have lost the stream.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        if (d_valid_i) begin
            case (state_q)
                FILL: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], d_i};
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d     = SEARCH;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end

                SEARCH: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], d_i};
                    if ((d_i == pred) && !lfsr_stuck) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], pred};
                    if (d_i != pred) begin
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d     = FILL;
                            fill_cnt_d  = '0;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end

                default: begin
                    state_d     = FILL;
                    fill_cnt_d  = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end
            endcase
        end
    end

    // Output logic. Only mispredictions while already LOCKED are errors;
    // disagreements during FILL and SEARCH are simply part of acquiring the
    // stream. The miss that drops lock still counts as an error. A clear
    // takes priority over a simultaneous increment, but the pulse still
    // fires so the event is not lost to an observer of err_o. The counter
    // holds at its maximum instead of wrapping back to a small value.
    always_comb begin
        err_d    = (state_q == LOCKED) && d_valid_i && (d_i != pred);
        locked_d = (state_d == LOCKED);

        if (clr_i) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Output register: every output comes straight from a flop, so locked_o
    // and err_o follow the deciding valid beat by exactly one cycle and a
    // reset clears the error count along with everything else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
//
// Drives two prbs_checker instances (16-bit and 3-bit error counters) with
// the same bit stream from an independent copy of the XNOR generator. Every
// beat pushes the expected locked/err/count values onto a scoreboard queue;
// the entry is popped and checked one cycle later, after the DUT has
// registered its response to that beat.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int WIDTH     = 8;
    localparam int LOCK_BEAT = 24;
    localparam int SAT_MAX   = 7;

    typedef struct {
        string       tag;
        logic        locked;
        logic        err;
        int unsigned cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        d = 1'b0;
    logic        d_valid = 1'b0;
    logic        clr = 1'b0;

    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        locked_sat;
    logic        err_sat;
    logic [2:0]  err_cnt_sat;

    logic [WIDTH-1:0] gen_state;
    exp_t             sb[$];
    int unsigned      exp_cnt;
    int               compared;
    int               mismatched;

    prbs_checker #(
        .WIDTH(WIDTH), .LOCK_COUNT(16), .LOSS_COUNT(4), .ERR_CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .d_i(d), .d_valid_i(d_valid), .clr_i(clr),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt)
    );

    prbs_checker #(
        .WIDTH(WIDTH), .LOCK_COUNT(16), .LOSS_COUNT(4), .ERR_CNT_W(3)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .d_i(d), .d_valid_i(d_valid), .clr_i(clr),
        .locked_o(locked_sat), .err_o(err_sat), .err_cnt_o(err_cnt_sat)
    );

    always #5 clk = ~clk;

    // Independent reference generator: shift left, new LSB is the XNOR of
    // the two top bits, and that new LSB is the transmitted bit.
    task automatic nextBit(output logic b);
        b = ~(gen_state[WIDTH-1] ^ gen_state[WIDTH-2]);
        gen_state = {gen_state[WIDTH-2:0], b};
    endtask

    // Pops the oldest expectation and compares both instances against it.
    task automatic checkOutput();
        exp_t        e;
        int unsigned sat_cnt;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        sat_cnt = (e.cnt > SAT_MAX) ? SAT_MAX : e.cnt;

        compared++;
        assert (locked === e.locked) else begin
            mismatched++;
            $error("[TB] FAIL %s locked observed=%0b expected=%0b", e.tag, locked, e.locked);
        end
        compared++;
        assert (err === e.err) else begin
            mismatched++;
            $error("[TB] FAIL %s err observed=%0b expected=%0b", e.tag, err, e.err);
        end
        compared++;
        assert (err_cnt === e.cnt[15:0]) else begin
            mismatched++;
            $error("[TB] FAIL %s err_cnt observed=%0d expected=%0d", e.tag, err_cnt, e.cnt);
        end
        compared++;
        assert (locked_sat === e.locked) else begin
            mismatched++;
            $error("[TB] FAIL %s locked_sat observed=%0b expected=%0b", e.tag, locked_sat, e.locked);
        end
        compared++;
        assert (err_sat === e.err) else begin
            mismatched++;
            $error("[TB] FAIL %s err_sat observed=%0b expected=%0b", e.tag, err_sat, e.err);
        end
        compared++;
        assert (err_cnt_sat === sat_cnt[2:0]) else begin
            mismatched++;
            $error("[TB] FAIL %s err_cnt_sat observed=%0d expected=%0d", e.tag, err_cnt_sat, sat_cnt);
        end
    endtask

    // Drives one beat, records what the DUT must show one cycle later, then
    // waits for that cycle and checks it.
    task automatic applyStimulus(input string tag, input logic bit_in,
                                 input logic valid, input logic clear,
                                 input logic reset, input logic exp_locked,
                                 input logic exp_err);
        exp_t e;
        d       = bit_in;
        d_valid = valid;
        clr     = clear;
        rst     = reset;
        if (reset || clear) begin
            exp_cnt = 0;
        end else if (exp_err) begin
            exp_cnt++;
        end
        e.tag    = tag;
        e.locked = exp_locked;
        e.err    = exp_err;
        e.cnt    = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic b;
        int   nvalid;
        exp_cnt    = 0;
        compared   = 0;
        mismatched = 0;
        gen_state  = '0;

        @(posedge clk);
        #1;

        $display("[TB] reset with a valid bit present");
        applyStimulus("reset", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("reset", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] clean lock from seed 0");
        gen_state = '0;
        for (int k = 1; k <= 1000; k++) begin
            nextBit(b);
            applyStimulus("clean_lock", b, 1'b1, 1'b0, 1'b0, k >= LOCK_BEAT, 1'b0);
        end

        $display("[TB] loss of lock after four inverted bits");
        for (int k = 1; k <= 4; k++) begin
            nextBit(b);
            applyStimulus("loss_of_lock", ~b, 1'b1, 1'b0, 1'b0, k < 4, 1'b1);
        end
        for (int k = 1; k <= 40; k++) begin
            nextBit(b);
            applyStimulus("relock", b, 1'b1, 1'b0, 1'b0, k >= LOCK_BEAT, 1'b0);
        end

        $display("[TB] single error while locked");
        nextBit(b);
        applyStimulus("single_error", ~b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            nextBit(b);
            applyStimulus("after_error", b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] random valid gaps while locked");
        for (int k = 1; k <= 400; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                nextBit(b);
                applyStimulus("gaps_valid", b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                applyStimulus("gaps_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        $display("[TB] counter saturation");
        for (int k = 1; k <= 10; k++) begin
            nextBit(b);
            applyStimulus("saturate_err", ~b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            nextBit(b);
            applyStimulus("saturate_ok", b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] clear against a simultaneous error");
        nextBit(b);
        applyStimulus("clear_with_error", ~b, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        nextBit(b);
        applyStimulus("after_clear", b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        nextBit(b);
        applyStimulus("pre_clear_error", ~b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        nextBit(b);
        applyStimulus("clear_plain", b, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset while locked");
        nextBit(b);
        applyStimulus("reset_locked", ~b, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] constant ones never lock");
        for (int k = 1; k <= 200; k++) begin
            applyStimulus("lockup_ones", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] lock from reset with gaps during fill and search");
        applyStimulus("reset_gapped", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        gen_state = '0;
        nvalid    = 0;
        while (nvalid < 60) begin
            if ($urandom_range(0, 2) != 0) begin
                nextBit(b);
                nvalid++;
                applyStimulus("gapped_lock_valid", b, 1'b1, 1'b0, 1'b0, nvalid >= LOCK_BEAT, 1'b0);
            end else begin
                applyStimulus("gapped_lock_idle", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                              nvalid >= LOCK_BEAT, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side checker for the team's XNOR-feedback LFSR pattern generator. It self-synchronises to the incoming bit stream, declares lock, and then free-runs a local LFSR copy to count bit errors. It sits at the far end of a serial link or loopback, downstream of the generator. It is used for link bring-up and bit-error-rate measurement on the ICE40 boards.

## Interface
- WIDTH, 8: LFSR length. Must be ≥ 3. Taps are fixed at bits WIDTH-1 and WIDTH-2, with XNOR feedback.
- LOCK_COUNT, 16: consecutive correct predictions required to enter LOCKED (≥ 1).
- LOSS_COUNT, 4: consecutive mispredictions in LOCKED that force resynchronisation (≥ 1).
- ERR_CNT_W, 16: width of the error counter.
- clk_i  in  1  sole clock; everything is on its rising edge.
- rst_i  in  1  reset. Synchronous, active-high.
- d_i  in  1  received serial bit.
- d_valid_i  in  1  d_i is sampled only when this is high.
- clr_i  in  1  synchronous clear of err_cnt_o.
- locked_o  out  1  high while in LOCKED.
- err_o  out  1  one-cycle pulse per mispredicted bit while LOCKED.
- err_cnt_o  out  ERR_CNT_W  saturating count of mispredicted bits while LOCKED.

## Operation
- Stream definition: each generator step shifts left, and the new LSB is ~(r[WIDTH-1] ^ r[WIDTH-2]). The transmitted bit is that new LSB.
- The local register lfsr_q has WIDTH bits. The predicted bit is pred = ~(lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-2]).
- Beats with d_valid_i low change nothing: no state change, no counter change, no pulse.
- States:
  - FILL:
    - Each valid beat performs lfsr_q <= {lfsr_q[WIDTH-2:0], d_i} and fill_cnt++.
    - After the WIDTH-th valid beat: go to SEARCH with match_cnt = 0.
  - SEARCH:
    - Each valid beat still loads d_i into lfsr_q.
    - If d_i == pred and lfsr_q is not all-ones: match_cnt++. Otherwise match_cnt = 0.
    - When match_cnt reaches LOCK_COUNT: go to LOCKED with miss_cnt = 0.
  - LOCKED:
    - Each valid beat loads pred, not d_i: lfsr_q <= {lfsr_q[WIDTH-2:0], pred}.
    - If d_i != pred: err_o pulses, err_cnt_o++, and miss_cnt++.
    - If d_i == pred: miss_cnt = 0.
    - When miss_cnt reaches LOSS_COUNT: go to FILL with fill_cnt = 0, match_cnt = 0 and miss_cnt = 0. err_cnt_o is retained.
- Lock-up state: all-ones is the XNOR LFSR lock-up state.
  - It never counts as a match in SEARCH.
  - A constant all-ones input therefore never locks.
- Error counter:
  - Saturates at 2^ERR_CNT_W − 1 and does not wrap.
  - clr_i beats an increment in the same cycle: the result is 0 and err_o still pulses.
- Errors are counted only in LOCKED. Mismatches in FILL and SEARCH are not errors.

## Timing
- Reset values: state = FILL, lfsr_q = 0, fill_cnt = match_cnt = miss_cnt = 0, locked_o = 0, err_o = 0, err_cnt_o = 0.
- All outputs are registered.
- locked_o rises the cycle after the valid beat that completes LOCK_COUNT matches.
  - Minimum lock time from reset: WIDTH + LOCK_COUNT valid beats.
- locked_o falls the cycle after the LOSS_COUNT-th consecutive miss.
  - That beat's err_o pulse and count still occur.
- err_o and err_cnt_o update one cycle after the offending valid beat, i.e. latency 1.
- rst_i mid-operation: the next cycle shows reset values, including err_cnt_o = 0. The bit sampled in the reset cycle is discarded.
- Back-to-back valid beats are supported at one bit per clock.

## Structure
- Shared package prbs_pkg holds:
  - the state encoding enum (FILL, SEARCH, LOCKED);
  - the tap-position constants;
  - the next-bit function prbs_next(lfsr, width), so the generator and checker cannot diverge.
- No sub-module. Keep a single module with one state register, three small counters and the error counter.
- Counter widths: fill_cnt is $clog2(WIDTH+1), match_cnt is $clog2(LOCK_COUNT+1), miss_cnt is $clog2(LOSS_COUNT+1).

## Test plan
- Clean lock:
  - Stimulus: generator seeded 0, WIDTH = 8, continuous valid. The stream starts 1,1,1,1,1,1,1,0.
  - Response: locked_o rises after exactly 24 valid beats, and err_cnt_o stays 0 over 1000 beats.
- Single error:
  - Stimulus: once locked, flip one bit.
  - Response: one err_o pulse one cycle later, err_cnt_o = 1, and locked_o stays high.
- Loss of lock:
  - Stimulus: once locked, invert 4 consecutive bits.
  - Response: err_cnt_o = 4, and locked_o falls after the 4th inverted bit.
  - Then: uninverted data relocks after a further 24 valid beats.
- Lock-up and gaps:
  - Stimulus: constant d_i = 1 for 200 beats.
  - Response: locked_o never rises.
  - Stimulus: a locked stream with d_valid_i toggling at random.
  - Response: no errors counted, and invalid beats are ignored.
- Saturation, clear and reset:
  - With ERR_CNT_W = 3, 10 errors saturate err_cnt_o at 7.
  - clr_i together with an error gives err_cnt_o = 0.
  - rst_i while locked gives locked_o = 0 and err_cnt_o = 0 on the next cycle.
